div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 155 +++++++++++++++
 tb/tb_div_iter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative 32-bit integer divider (signed DIV / unsigned DIVU)
//
// A restoring shift-subtract divider that produces one quotient bit per cycle,
// MSB first. Operands are converted to magnitudes when the request is accepted.
// The final sign correction, or the divide-by-zero substitution, is applied
// when the result registers are loaded.
//
// Ports
//   clk        in   1   system clock; all state updates on the rising edge
//   rst        in   1   asynchronous active-low reset
//   dividend   in  32   numerator, sampled only on an accepted start
//   divisor    in  32   denominator, sampled only on an accepted start
//   sign       in   1   1 = signed (DIV), 0 = unsigned (DIVU)
//   start      in   1   request, level-sampled each rising edge
//   busy       out  1   high while an operation is in progress (32 cycles)
//   done       out  1   one-cycle pulse: q/r/dbz have just been updated
//   q          out 32   quotient, held until the next completion
//   r          out 32   remainder, held until the next completion
//   dbz        out  1   divisor was zero for the last completed operation
//   state_dbg  out  1   current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a request is accepted at a rising edge where start=1 and busy=0.
// Requests made while busy=1 are ignored. busy is high for exactly 32 cycles
// after the accepting edge. done pulses in the first cycle after busy falls.
// A start in that cycle is accepted, which gives one result every 33 cycles.
// -----------------------------------------------------------------------------
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        sign,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dbz,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;

  // Captured operation context
  logic [31:0] dq;        // dividend magnitude shifting out / quotient shifting in
  logic [32:0] rem;       // partial remainder
  logic [31:0] b_mag;     // divisor magnitude
  logic [31:0] dvd_raw;   // original dividend, returned as r on divide-by-zero
  logic        neg_q;
  logic        neg_r;
  logic        zero_div;

  // Iteration datapath
  logic [32:0] rem_sh;
  logic        ge;
  logic [32:0] rem_nxt;
  logic [31:0] dq_nxt;
  logic        last;
  logic        accept;
  logic [31:0] q_res;
  logic [31:0] r_res;

  assign busy      = (state == RUN);
  assign state_dbg = state;
  assign accept    = (state == IDLE) && start;
  assign last      = (cnt == 5'd31);

  // One restoring step. The partial remainder is always below the divisor.
  // The shifted value therefore fits in 33 bits, and a plain compare decides
  // whether this step subtracts.
  always_comb begin
    rem_sh  = {rem[31:0], dq[31]};
    ge      = (rem_sh >= {1'b0, b_mag});
    rem_nxt = ge ? (rem_sh - {1'b0, b_mag}) : rem_sh;
    dq_nxt  = {dq[30:0], ge};
  end

  // Final result formed from this cycle's step outputs. Negating zero yields
  // zero, so a zero result stays unsigned. The 0x80000000 / -1 case gives a
  // magnitude of 0x80000000 with neg_q = 0, which is already the required
  // value.
  always_comb begin
    q_res = 32'd0;
    r_res = 32'd0;
    if (zero_div) begin
      q_res = 32'hFFFF_FFFF;
      r_res = dvd_raw;
    end else begin
      q_res = neg_q ? (32'd0 - dq_nxt) : dq_nxt;
      r_res = neg_r ? (32'd0 - rem_nxt[31:0]) : rem_nxt[31:0];
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 5'd0;
      dq       <= 32'd0;
      rem      <= 33'd0;
      b_mag    <= 32'd0;
      dvd_raw  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      done     <= 1'b0;
      q        <= 32'd0;
      r        <= 32'd0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt      <= 5'd0;
        rem      <= 33'd0;
        dq       <= (sign && dividend[31]) ? (32'd0 - dividend) : dividend;
        b_mag    <= (sign && divisor[31])  ? (32'd0 - divisor)  : divisor;
        dvd_raw  <= dividend;
        neg_q    <= sign && (dividend[31] ^ divisor[31]);
        neg_r    <= sign && dividend[31];
        zero_div <= (divisor == 32'd0);
      end else if (state == RUN) begin
        rem <= rem_nxt;
        dq  <= dq_nxt;
        cnt <= cnt + 5'd1;
        if (last) begin
          q    <= q_res;
          r    <= r_res;
          dbz  <= zero_div;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter -- self-checking bench for div_iter.
// The stimulus consists of directed steps followed by a run of randomized
// operations. Expected results come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        sign;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dbz;
  logic        state_dbg;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_r[$];
  logic [31:0] exp_z[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .dividend  (dividend),
    .divisor   (divisor),
    .sign      (sign),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .dbz       (dbz),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] eq,
                                  output logic [31:0] er, output logic ez);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
      ez = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;            // truncates toward zero
      lr = sa % sb;            // takes the sign of the dividend
      eq = lq[31:0];
      er = lr[31:0];
      ez = 1'b0;
    end else begin
      eq = a / b;
      er = a % b;
      ez = 1'b0;
    end
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks are entered and left just after a falling edge.
  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  // Issue one operation and follow it to completion. When hold is set, start
  // stays high during RUN. When chg is set, the operands are scrambled at
  // cycle 5.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit hold, input bit chg, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    logic [31:0] prev_q;
    logic [31:0] prev_r;
    logic [31:0] prev_z;
    ref_div(a, b, s, eq, er, ez);
    exp_q.push_back(eq);
    exp_r.push_back(er);
    exp_z.push_back({31'd0, ez});
    prev_q   = q;
    prev_r   = r;
    prev_z   = {31'd0, dbz};
    dividend = a;
    divisor  = b;
    sign     = s;
    start    = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i == 0) start = hold;
      if (chg && i == 5) begin
        dividend = $urandom;
        divisor  = $urandom_range(0, 3);
        sign     = ~s;
      end
      if (i < 32) begin
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        chk({tag, "_q_hold"}, q, prev_q);
        chk({tag, "_r_hold"}, r, prev_r);
        chk({tag, "_dbz_hold"}, {31'd0, dbz}, prev_z);
      end else begin
        start = 1'b0;
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_q"}, q, exp_q.pop_front());
        chk({tag, "_r"}, r, exp_r.pop_front());
        chk({tag, "_dbz"}, {31'd0, dbz}, exp_z.pop_front());
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    sign     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    rst = 1'b1;
    idle_cycle();

    // Directed cases
    do_op(32'd100, 32'd7, 1'b0, 0, 0, "u100_7");
    idle_cycle();
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, "sm7_2");
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0, "s7_m2");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, "s_ovf");
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, "u_max_1");
    do_op(32'd5, 32'd0, 1'b0, 0, 0, "u_dbz");
    do_op(32'd5, 32'd0, 1'b1, 0, 0, "s_dbz");
    do_op(32'd10, 32'd3, 1'b0, 0, 0, "u10_3");
    do_op(32'hFFFF_FFF6, 32'd0, 1'b1, 0, 0, "s_neg_dbz");
    idle_cycle();

    // start held through RUN, operands changed at cycle 5
    do_op(32'd1000, 32'd33, 1'b0, 1, 1, "hold");
    idle_cycle();

    // Reset in the middle of an operation
    dividend = 32'd100;
    divisor  = 32'd7;
    sign     = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_r", r, 32'd0);
    chk("mid_rst_dbz", {31'd0, dbz}, 32'd0);
    start = 1'b1;                 // must be ignored while in reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst_busy", {31'd0, busy}, 32'd0);
      chk("in_rst_done", {31'd0, done}, 32'd0);
    end
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 25; i++) idle_cycle();  // no stale done from the aborted op
    do_op(32'd9, 32'd4, 1'b0, 0, 0, "after_rst");
    idle_cycle();

    // Randomized operations, some back-to-back
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 16);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
        3:       rb = ra;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, bit'($urandom_range(0, 3) == 0), 0, "rand");
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Overall time bound so the bench always terminates
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "timeout");
  end

endmodule
